// File: rtl/apx_mul_rr_scheduler_if.sv
// Bundle of requester-side and multiplier-side signals for the round-robin multiplier scheduler.
// slave is the scheduler's view, master is the environment's (requesters + multiplier) view.
interface apx_mul_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0][31:0]  req_a;
  logic [NUM_REQ-1:0][31:0]  req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [31:0]               rsp_z;
  logic [31:0]               mul_input_a;
  logic                      mul_input_a_stb;
  logic                      mul_input_a_ack;
  logic [31:0]               mul_input_b;
  logic                      mul_input_b_stb;
  logic                      mul_input_b_ack;
  logic [31:0]               mul_output_z;
  logic                      mul_output_z_stb;
  logic                      mul_output_z_ack;
  logic                      busy;
  logic [IDX_W-1:0]          grant_idx;
  logic [CNT_W-1:0]          op_count;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
           mul_input_a_ack, mul_input_b_ack, mul_output_z, mul_output_z_stb,
    output req_ready, rsp_valid, rsp_z,
           mul_input_a, mul_input_a_stb, mul_input_b, mul_input_b_stb, mul_output_z_ack,
           busy, grant_idx, op_count
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
           mul_input_a_ack, mul_input_b_ack, mul_output_z, mul_output_z_stb,
    input  req_ready, rsp_valid, rsp_z,
           mul_input_a, mul_input_a_stb, mul_input_b, mul_input_b_stb, mul_output_z_ack,
           busy, grant_idx, op_count
  );
endinterface

// File: rtl/apx_mul_rr_scheduler.sv
// Round-robin scheduler sharing one stb/ack approximate FP multiplier among NUM_REQ requesters;
// one operation in flight, every output comes straight from a register.
module apx_mul_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  apx_mul_rr_scheduler_if.slave bus
);
  typedef enum logic [2:0] {ARB, SEND_A, SEND_B, WAIT_Z, RESP} state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  state_e             state_q;
  logic [IDX_W-1:0]   last_q, idx_q;
  logic [NUM_REQ-1:0] req_ready_q, rsp_valid_q;
  op_t                op_q;
  logic [31:0]        z_q;
  logic               a_stb_q, b_stb_q, z_ack_q, busy_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               found_d;
  logic [IDX_W-1:0]   pick_d;
  logic [IDX_W-1:0]   scan_d;

  // Scan from the requester after the last one served, wrapping once around.
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    scan_d  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_d = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found_d && bus.req_valid[scan_d]) begin
        found_d = 1'b1;
        pick_d  = scan_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB;
      last_q      <= IDX_W'(NUM_REQ - 1);
      idx_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      op_q        <= '0;
      z_q         <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        ARB: if (found_d) begin
          req_ready_q <= NUM_REQ'(1) << pick_d;
          op_q        <= '{a: bus.req_a[pick_d], b: bus.req_b[pick_d]};
          idx_q       <= pick_d;
          a_stb_q     <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= SEND_A;
        end
        SEND_A: if (a_stb_q && bus.mul_input_a_ack) begin
          a_stb_q <= 1'b0;
          b_stb_q <= 1'b1;
          state_q <= SEND_B;
        end
        SEND_B: if (b_stb_q && bus.mul_input_b_ack) begin
          b_stb_q <= 1'b0;
          z_ack_q <= 1'b1;
          state_q <= WAIT_Z;
        end
        WAIT_Z: if (z_ack_q && bus.mul_output_z_stb) begin
          z_q         <= bus.mul_output_z;
          z_ack_q     <= 1'b0;
          rsp_valid_q <= NUM_REQ'(1) << idx_q;
          state_q     <= RESP;
        end
        // Only the owner's rsp_ready retires the operation.
        RESP: if (bus.rsp_ready[idx_q]) begin
          rsp_valid_q <= '0;
          last_q      <= idx_q;
          cnt_q       <= cnt_q + 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_z            = z_q;
  assign bus.mul_input_a      = op_q.a;
  assign bus.mul_input_a_stb  = a_stb_q;
  assign bus.mul_input_b      = op_q.b;
  assign bus.mul_input_b_stb  = b_stb_q;
  assign bus.mul_output_z_ack = z_ack_q;
  assign bus.busy             = busy_q;
  assign bus.grant_idx        = idx_q;
  assign bus.op_count         = cnt_q;
endmodule

// File: tb/tb_apx_mul_rr_scheduler.sv
// Directed + randomized bench: requester queues, a stb/ack multiplier model and a
// round-robin reference scoreboard drive and judge the scheduler.
module tb_apx_mul_rr_scheduler;
  localparam int N = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk, rst;
  apx_mul_rr_scheduler_if #(.NUM_REQ(N), .IDX_W(2), .CNT_W(16)) bus ();
  apx_mul_rr_scheduler #(.NUM_REQ(N), .IDX_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err;
  op_t reqq [N][$];
  int  grants[$];
  int  acked[N];
  int  model_last, model_cnt, inflight_g;
  op_t inflight_op;
  logic [N-1:0] rsp_mask;
  bit  rand_rsp;
  int  a_delay, b_delay, z_delay, a_cnt, b_cnt, z_cnt;
  bit  z_busy;
  logic [31:0] a_cap, b_cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Truncating FP32 multiply for normal operands; the multiplier model and scoreboard both use it.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int e;
    logic [22:0] f;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      f = p[46:24];
      e++;
    end else f = p[45:23];
    return {a[31] ^ b[31], 8'(e), f};
  endfunction

  // Reference arbitration: the valid requester at the smallest forward distance after last.
  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    int best, bestd, d;
    best = -1; bestd = 99;
    for (int j = 0; j < N; j++) if (v[j]) begin
      d = (j - last - 1 + 2 * N) % N;
      if (d < bestd) begin bestd = d; best = j; end
    end
    return best;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    o.b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    return o;
  endfunction

  task automatic update_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (reqq[i].size() > 0);
      bus.req_a[i]     = (reqq[i].size() > 0) ? reqq[i][0].a : 32'h0;
      bus.req_b[i]     = (reqq[i].size() > 0) ? reqq[i][0].b : 32'h0;
    end
  endtask

  task automatic models_reset();
    bus.mul_input_a_ack  = 1'b0;
    bus.mul_input_b_ack  = 1'b0;
    bus.mul_output_z_stb = 1'b0;
    bus.mul_output_z     = 32'h0;
    a_cnt = 0; b_cnt = 0; z_cnt = 0; z_busy = 1'b0;
    inflight_g = -1; model_last = N - 1; model_cnt = 0;
    for (int i = 0; i < N; i++) reqq[i].delete();
    update_reqs();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_z"}, bus.rsp_z, 32'h0);
    chk({tag, "_mul_ab"}, bus.mul_input_a | bus.mul_input_b, 32'h0);
    chk({tag, "_hs"}, {29'h0, bus.mul_input_a_stb, bus.mul_input_b_stb, bus.mul_output_z_ack}, 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_grant_idx"}, 32'(bus.grant_idx), 32'h0);
    chk({tag, "_op_count"}, 32'(bus.op_count), 32'h0);
  endtask

  // One clock: snapshot pre-edge signals, step, then advance models and scoreboard.
  task automatic cyc();
    logic pa_stb, pa_ack, pb_stb, pb_ack, pz_stb, pz_ack;
    logic [N-1:0] pv, prv, prr;
    int g;
    pa_stb = bus.mul_input_a_stb; pa_ack = bus.mul_input_a_ack;
    pb_stb = bus.mul_input_b_stb; pb_ack = bus.mul_input_b_ack;
    pz_stb = bus.mul_output_z_stb; pz_ack = bus.mul_output_z_ack;
    pv = bus.req_valid; prv = bus.rsp_valid; prr = bus.rsp_ready;
    @(posedge clk); #1;
    if (pa_stb && !pa_ack) chk("a_stb_hold", 32'(bus.mul_input_a_stb), 32'h1);
    if (pb_stb && !pb_ack) chk("b_stb_hold", 32'(bus.mul_input_b_stb), 32'h1);
    if (pz_ack && !pz_stb) chk("z_ack_hold", 32'(bus.mul_output_z_ack), 32'h1);
    chk("hs_exclusive", 32'($countones({bus.mul_input_a_stb, bus.mul_input_b_stb, bus.mul_output_z_ack}) <= 1), 32'h1);
    if (pa_stb && pa_ack) begin bus.mul_input_a_ack = 1'b0; a_cnt = 0; end
    else if (bus.mul_input_a_stb && !bus.mul_input_a_ack) begin
      if (a_cnt >= a_delay) begin bus.mul_input_a_ack = 1'b1; a_cap = bus.mul_input_a; end
      else a_cnt++;
    end
    if (pb_stb && pb_ack) begin bus.mul_input_b_ack = 1'b0; b_cnt = 0; z_busy = 1'b1; z_cnt = 0; end
    else if (bus.mul_input_b_stb && !bus.mul_input_b_ack) begin
      if (b_cnt >= b_delay) begin bus.mul_input_b_ack = 1'b1; b_cap = bus.mul_input_b; end
      else b_cnt++;
    end
    if (pz_stb && pz_ack) begin bus.mul_output_z_stb = 1'b0; z_busy = 1'b0; end
    else if (z_busy && !bus.mul_output_z_stb) begin
      if (z_cnt >= z_delay) begin bus.mul_output_z_stb = 1'b1; bus.mul_output_z = fp_mul(a_cap, b_cap); end
      else z_cnt++;
    end
    if (bus.req_ready != '0) begin
      g = rr_ref(pv, model_last);
      chk("grant_onehot", 32'(bus.req_ready), (g >= 0) ? 32'(1) << g : 32'hFFFF_FFFF);
      chk("grant_idx", 32'(bus.grant_idx), 32'(g));
      chk("busy_after_grant", 32'(bus.busy), 32'h1);
      if (g >= 0) begin
        inflight_op = reqq[g].pop_front();
        inflight_g = g; model_last = g; acked[g]++;
        grants.push_back(g);
        chk("grant_opa", bus.mul_input_a, inflight_op.a);
        chk("grant_opb", bus.mul_input_b, inflight_op.b);
      end
    end
    if ((prv & prr) != '0) begin
      model_cnt++; inflight_g = -1;
      chk("op_count", 32'(bus.op_count), 32'(model_cnt));
      chk("busy_after_consume", 32'(bus.busy), 32'h0);
      chk("rsp_cleared", 32'(bus.rsp_valid), 32'h0);
    end
    if (bus.rsp_valid != '0 && prv == '0) begin
      chk("rsp_owner", 32'(bus.rsp_valid), (inflight_g >= 0) ? 32'(1) << inflight_g : 32'hFFFF_FFFF);
      chk("rsp_z", bus.rsp_z, fp_mul(inflight_op.a, inflight_op.b));
    end
    bus.rsp_ready = rand_rsp ? N'($urandom) : rsp_mask;
    update_reqs();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      if (inflight_g < 0 && bus.busy == 1'b0 && reqq[0].size() + reqq[1].size() + reqq[2].size() + reqq[3].size() == 0) break;
      cyc(); n++;
    end
    if (n >= budget) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk_zero("reset");
    models_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] zv, av;
    n_cmp = 0; n_err = 0;
    rsp_mask = '1; rand_rsp = 1'b0;
    a_delay = 0; b_delay = 0; z_delay = 1;
    bus.rsp_ready = '1;
    for (int i = 0; i < N; i++) acked[i] = 0;
    rst = 1'b1;
    models_reset();
    #1;
    do_reset();

    // Single operation: 1.5 * 2.0 from requester 0
    reqq[0].push_back('{a: 32'h3FC0_0000, b: 32'h4000_0000});
    update_reqs();
    n = 0;
    while (bus.rsp_valid == '0 && n < 50) begin cyc(); n++; end
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_z", bus.rsp_z, 32'h4040_0000);
    cyc();
    chk("t1_op_count", 32'(bus.op_count), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h0);

    // All requesters valid after reset: order 0,1,2,3,0
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) acked[i] = 0;
    reqq[0].push_back(rand_op()); reqq[0].push_back(rand_op());
    for (int i = 1; i < N; i++) reqq[i].push_back(rand_op());
    update_reqs();
    run_idle(500);
    chk("t2_ngrants", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      chk("t2_g0", 32'(grants[0]), 32'd0); chk("t2_g1", 32'(grants[1]), 32'd1);
      chk("t2_g2", 32'(grants[2]), 32'd2); chk("t2_g3", 32'(grants[3]), 32'd3);
      chk("t2_g4", 32'(grants[4]), 32'd0);
    end
    chk("t2_acked", {acked[0][7:0], acked[1][7:0], acked[2][7:0], acked[3][7:0]}, 32'h02010101);

    // Only requesters 1 and 3 active
    grants.delete();
    for (int i = 0; i < N; i++) acked[i] = 0;
    for (int k = 0; k < 2; k++) begin reqq[1].push_back(rand_op()); reqq[3].push_back(rand_op()); end
    update_reqs();
    run_idle(500);
    chk("t3_ngrants", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      chk("t3_g0", 32'(grants[0]), 32'd1); chk("t3_g1", 32'(grants[1]), 32'd3);
      chk("t3_g2", 32'(grants[2]), 32'd1); chk("t3_g3", 32'(grants[3]), 32'd3);
    end
    chk("t3_r0_r2_idle", 32'(acked[0] + acked[2]), 32'h0);

    // Response back-pressure on requester 2
    rsp_mask = 4'b1011;
    reqq[2].push_back(rand_op());
    update_reqs();
    n = 0;
    while (bus.rsp_valid == '0 && n < 50) begin cyc(); n++; end
    zv = bus.rsp_z;
    reqq[0].push_back(rand_op());
    update_reqs();
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("t4_rsp_z", bus.rsp_z, zv);
      chk("t4_no_ready", 32'(bus.req_ready), 32'h0);
      chk("t4_mul_quiet", {29'h0, bus.mul_input_a_stb, bus.mul_input_b_stb, bus.mul_output_z_ack}, 32'h0);
    end
    rsp_mask = '1;
    run_idle(500);

    // Slow a-port acknowledge
    a_delay = 5;
    reqq[1].push_back(rand_op());
    update_reqs();
    n = 0;
    while (!bus.mul_input_a_stb && n < 20) begin cyc(); n++; end
    av = bus.mul_input_a;
    n = 0;
    while (bus.mul_input_a_stb && n < 30) begin
      chk("t5_a_stable", bus.mul_input_a, av);
      chk("t5_b_idle", 32'(bus.mul_input_b_stb), 32'h0);
      cyc(); n++;
    end
    chk("t5_a_len", 32'(n >= 5), 32'h1);
    chk("t5_b_rise", 32'(bus.mul_input_b_stb), 32'h1);
    a_delay = 0;
    run_idle(500);

    // Reset while waiting for z
    z_delay = 20;
    reqq[3].push_back(rand_op());
    update_reqs();
    n = 0;
    while (!bus.mul_output_z_ack && n < 50) begin cyc(); n++; end
    chk("t6_in_wait_z", 32'(bus.mul_output_z_ack), 32'h1);
    #2;
    do_reset();
    z_delay = 1;
    grants.delete();
    reqq[0].push_back(rand_op()); reqq[2].push_back(rand_op());
    update_reqs();
    cyc();
    chk("t6_no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
    run_idle(500);
    chk("t6_first_grant", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'h0);
    chk("t6_op_count", 32'(bus.op_count), 32'h2);

    // Randomized traffic with random back-pressure and multiplier latencies
    rand_rsp = 1'b1;
    for (int k = 0; k < 40; k++) reqq[$urandom_range(0, N - 1)].push_back(rand_op());
    update_reqs();
    n = 0;
    while (n < 6000 && (inflight_g >= 0 || bus.busy || reqq[0].size() + reqq[1].size() + reqq[2].size() + reqq[3].size() != 0)) begin
      a_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3); z_delay = $urandom_range(0, 4);
      cyc(); n++;
    end
    chk("rand_done", 32'(n < 6000), 32'h1);
    chk("rand_op_count", 32'(bus.op_count), 32'(model_cnt));
    chk("rand_count_total", 32'(model_cnt), 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
